// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result collector: default widths, opcode
// encodings and the buffered result record.
package alu_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SEL_W = 3;

  typedef enum logic [DEF_SEL_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_GT  = 3'b101,
    OP_EQ  = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic [DEF_SEL_W-1:0] sel;
    logic [DEF_WIDTH-1:0] data;
    logic                 carry;
    logic                 zero;
  } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// DEPTH-entry synchronous FIFO with an explicit occupancy count. The head is
// presented combinationally and reads as zero while the FIFO is empty.
module alu_res_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, do_push, do_pop;
  logic             overflow_q;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      overflow_q <= overflow_q | (push_i & full);
    end
  end

  // NOTE: storage is deliberately not reset; an empty FIFO never exposes it because the head is gated below.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Credit-based issue control makes a dropped push impossible.
  assert property (@(posedge clk) disable iff (rst) !overflow_q);

endmodule

// File: rtl/alu_result_collector.sv
// Tracks ops issued to a fixed-latency pipelined ALU, captures each result as it
// emerges and buffers it for a valid/ready consumer, with credit-based issue_ready.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [SEL_W-1:0] issue_sel,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_sel,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [7:0]       res_count
);

  localparam int ENTRY_W = SEL_W + WIDTH + 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int SUM_W   = $clog2(DEPTH + LATENCY + 1) + 1;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
  } entry_t;

  logic [LATENCY-1:0] tag_vld_q;
  logic [SEL_W-1:0]   tag_sel_q [LATENCY];
  logic               issue_fire, res_fire, fifo_empty;
  logic [SUM_W-1:0]   inflight, credit_used;
  logic [CNT_W-1:0]   fifo_count;
  entry_t             push_entry, head_entry;
  logic [7:0]         res_count_q, res_count_d;

  assign issue_fire = issue_valid & issue_ready;

  // The tag pipeline mirrors the ALU pipeline one-for-one and never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sel_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= issue_fire;
      tag_sel_q[0] <= issue_sel;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_sel_q[i] <= tag_sel_q[i-1];
      end
    end
  end

  // Every in-flight op already owns a FIFO slot, so a capture can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SUM_W'(tag_vld_q[i]);
    credit_used = SUM_W'(fifo_count) + inflight;
    issue_ready = ~rst & (credit_used < SUM_W'(DEPTH));
  end

  always_comb begin
    push_entry.sel   = tag_sel_q[LATENCY-1];
    push_entry.data  = alu_result;
    push_entry.carry = carry_out;
    push_entry.zero  = (alu_result == '0);
  end

  alu_res_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tag_vld_q[LATENCY-1]),
    .push_data_i (push_entry),
    .pop_i       (res_fire),
    .head_o      (head_entry),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_fire  = res_valid & res_ready;
  assign res_sel   = head_entry.sel;
  assign res_data  = head_entry.data;
  assign res_carry = head_entry.carry;
  assign res_zero  = head_entry.zero;

  always_comb begin
    res_count_d = res_count_q;
    if (res_fire && (res_count_q != 8'hFF)) res_count_d = res_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_count_q <= '0;
    else     res_count_q <= res_count_d;
  end

  assign res_count = res_count_q;

endmodule
